// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - 24-hour timekeeping core with RUN/EDIT time setting
//
// Purpose: keeps an hh:mm:ss count from a CLK_HZ-cycle prescaler. EDIT mode
//   pauses counting and lets the button pulses select and adjust one field;
//   pulseC toggles between RUN and EDIT.
// Optional feature: define TIME_SET_TIMEOUT_EN to leave EDIT automatically
//   after TIMEOUT_S seconds without an accepted button pulse.
// Ports:
//   clk                        system clock
//   reset                      synchronous, active-high
//   pulseU/D/L/R/C             single-cycle button pulses (priority C>U>D>L>R)
//   hours/minutes/seconds      current time, registered
//   edit_mode                  1 = EDIT, 0 = RUN
//   edit_field                 selected field: 0 hours, 1 minutes, 2 seconds
//   blink                      blank phase for the selected field
//   sec_tick                   one-cycle strobe per RUN-mode second
module time_set_controller #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulseU,
  input  logic       pulseD,
  input  logic       pulseL,
  input  logic       pulseR,
  input  logic       pulseC,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       edit_mode,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic       sec_tick
);

  localparam int HALF_HZ = CLK_HZ / 2;
  localparam int PW      = $clog2(CLK_HZ);
  localparam int BW      = $clog2(HALF_HZ + 1);

  typedef enum logic {S_RUN = 1'b0, S_EDIT = 1'b1} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   presc, presc_next;
  logic [BW-1:0]   blink_cnt, blink_cnt_next;
  logic [4:0]      hours_next;
  logic [5:0]      minutes_next, seconds_next;
  logic [1:0]      field_next;
  logic            blink_next, sec_tick_next;

  logic act_c, act_u, act_d, act_l, act_r, any_act;
  logic tick_due, blink_wrap, timeout, leave_edit;

  // Wrap helpers: each field stays in its own width with explicit compare-and-wrap.
  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec24(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // One action per cycle; lower-priority pulses in the same cycle are dropped.
  assign act_c   = pulseC;
  assign act_u   = pulseU & ~pulseC;
  assign act_d   = pulseD & ~pulseC & ~pulseU;
  assign act_l   = pulseL & ~pulseC & ~pulseU & ~pulseD;
  assign act_r   = pulseR & ~pulseC & ~pulseU & ~pulseD & ~pulseL;
  assign any_act = act_c | act_u | act_d | act_l | act_r;

  assign tick_due   = (state == S_RUN)  && (presc == PW'(CLK_HZ - 1));
  assign blink_wrap = (state == S_EDIT) && (blink_cnt == BW'(HALF_HZ - 1));
  assign leave_edit = (state == S_EDIT) && (act_c || timeout);
  assign edit_mode  = (state == S_EDIT);

`ifdef TIME_SET_TIMEOUT_EN
  // Idle time is measured in blink periods: two blink wraps make one second.
  localparam int IDLE_LIMIT = TIMEOUT_S * 2 * HALF_HZ;
  localparam int IW         = $clog2(IDLE_LIMIT + 1);

  logic [IW-1:0] idle_cnt, idle_cnt_next;

  assign timeout = (state == S_EDIT) && !any_act && (idle_cnt == IW'(IDLE_LIMIT - 1));

  always_comb begin
    idle_cnt_next = '0;
    if ((state == S_EDIT) && !any_act && !timeout)
      idle_cnt_next = idle_cnt + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) idle_cnt <= '0;
    else       idle_cnt <= idle_cnt_next;
  end
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_S;
  assign timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (act_c)      state_next = S_EDIT;
      S_EDIT:  if (leave_edit) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    presc_next     = presc;
    blink_cnt_next = blink_cnt;
    hours_next     = hours;
    minutes_next   = minutes;
    seconds_next   = seconds;
    field_next     = edit_field;
    blink_next     = blink;
    sec_tick_next  = 1'b0;
    case (state)
      S_RUN: begin
        blink_cnt_next = '0;
        if (tick_due) begin
          presc_next    = '0;
          sec_tick_next = 1'b1;
          seconds_next  = inc60(seconds);
          if (seconds == 6'd59) begin
            minutes_next = inc60(minutes);
            if (minutes == 6'd59)
              hours_next = inc24(hours);
          end
        end else begin
          presc_next = presc + PW'(1);
        end
        // Entering EDIT: a tick due on this same edge has already been applied above.
        if (act_c) begin
          presc_next = '0;
          field_next = 2'd0;
          blink_next = 1'b1;
        end
      end
      S_EDIT: begin
        presc_next = '0;
        if (act_u || act_d) begin
          case (edit_field)
            2'd0:    hours_next   = act_u ? inc24(hours)   : dec24(hours);
            2'd1:    minutes_next = act_u ? inc60(minutes) : dec60(minutes);
            2'd2:    seconds_next = act_u ? inc60(seconds) : dec60(seconds);
            default: ;
          endcase
        end
        if (act_r) field_next = (edit_field == 2'd2) ? 2'd0 : edit_field + 2'd1;
        if (act_l) field_next = (edit_field == 2'd0) ? 2'd2 : edit_field - 2'd1;
        if (blink_wrap) begin
          blink_cnt_next = '0;
          blink_next     = ~blink;
        end else begin
          blink_cnt_next = blink_cnt + BW'(1);
        end
        // Prescaler is already 0, so the first RUN tick lands CLK_HZ cycles later.
        if (leave_edit) begin
          blink_next     = 1'b0;
          blink_cnt_next = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      blink_cnt  <= '0;
      hours      <= 5'd0;
      minutes    <= 6'd0;
      seconds    <= 6'd0;
      edit_field <= 2'd0;
      blink      <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      presc      <= presc_next;
      blink_cnt  <= blink_cnt_next;
      hours      <= hours_next;
      minutes    <= minutes_next;
      seconds    <= seconds_next;
      edit_field <= field_next;
      blink      <= blink_next;
      sec_tick   <= sec_tick_next;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - scoreboard bench for time_set_controller
module tb_time_set_controller;

  localparam int CLK_HZ    = 4;
  localparam int TIMEOUT_S = 2;

  localparam logic [4:0] P_N = 5'b00000;
  localparam logic [4:0] P_C = 5'b10000;
  localparam logic [4:0] P_U = 5'b01000;
  localparam logic [4:0] P_D = 5'b00100;
  localparam logic [4:0] P_L = 5'b00010;
  localparam logic [4:0] P_R = 5'b00001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulseU = 1'b0, pulseD = 1'b0, pulseL = 1'b0, pulseR = 1'b0, pulseC = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       edit_mode;
  logic [1:0] edit_field;
  logic       blink, sec_tick;

  always #5 clk = ~clk;

  time_set_controller #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
    .clk(clk), .reset(reset),
    .pulseU(pulseU), .pulseD(pulseD), .pulseL(pulseL), .pulseR(pulseR), .pulseC(pulseC),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .edit_mode(edit_mode), .edit_field(edit_field), .blink(blink), .sec_tick(sec_tick)
  );

  typedef struct {
    logic [20:0] v;
    logic        b;
    logic        cb;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  function automatic logic [20:0] pk(input int h, input int m, input int s,
                                     input int em, input int f, input int tk);
    return {5'(h), 6'(m), 6'(s), 1'(em), 2'(f), 1'(tk)};
  endfunction

  function automatic logic [20:0] snap();
    return {hours, minutes, seconds, edit_mode, edit_field, sec_tick};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [4:0] p);
    {pulseC, pulseU, pulseD, pulseL, pulseR} = p;
    step();
    {pulseC, pulseU, pulseD, pulseL, pulseR} = 5'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {pulseC, pulseU, pulseD, pulseL, pulseR} = 5'b11111;
    sb.push_back('{pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
    step();
    {pulseC, pulseU, pulseD, pulseL, pulseR} = 5'b0;
    reset = 1'b0;
    e = sb.pop_front();
    total++;
    if (snap() !== e.v || (e.cb && blink !== e.b)) begin
      bad++;
      $display("FAIL reset: got %h blink %b, want %h blink %b", snap(), blink, e.v, e.b);
    end
  endtask

  task automatic test_run_count();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{pk(0, 0, k / 4, 0, 0, (k % 4 == 0) ? 1 : 0), 1'b0, 1'b1});
      step();
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL run_count cycle %0d: got %h blink %b, want %h blink %b", k, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_preload_wrap();
    logic [4:0] p [0:7];
    exp_t       x [0:7];
    p = '{P_C, P_D, P_R, P_D, P_R, P_D, P_R, P_C};
    x = '{'{pk(0, 0, 0, 1, 0, 0), 1'b1, 1'b1},
          '{pk(23, 0, 0, 1, 0, 0), 1'b0, 1'b0},
          '{pk(23, 0, 0, 1, 1, 0), 1'b0, 1'b0},
          '{pk(23, 59, 0, 1, 1, 0), 1'b0, 1'b0},
          '{pk(23, 59, 0, 1, 2, 0), 1'b0, 1'b0},
          '{pk(23, 59, 59, 1, 2, 0), 1'b0, 1'b0},
          '{pk(23, 59, 59, 1, 0, 0), 1'b0, 1'b0},
          '{pk(23, 59, 59, 0, 0, 0), 1'b0, 1'b1}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sb.push_back(x[i]);
      apply(p[i]);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL preload step %0d: got %h blink %b, want %h blink %b", i, snap(), blink, e.v, e.b);
      end
    end
    for (int k = 1; k <= 7; k++) begin
      if (k < 4)       sb.push_back('{pk(23, 59, 59, 0, 0, 0), 1'b0, 1'b1});
      else if (k == 4) sb.push_back('{pk(0, 0, 0, 0, 0, 1), 1'b0, 1'b1});
      else             sb.push_back('{pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
      step();
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL day_wrap cycle %0d: got %h blink %b, want %h blink %b", k, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_blink();
    logic [4:0] p [0:5];
    exp_t       x [0:5];
    p = '{P_C, P_N, P_N, P_N, P_N, P_C};
    x = '{'{pk(0, 0, 0, 1, 0, 0), 1'b1, 1'b1},
          '{pk(0, 0, 0, 1, 0, 0), 1'b1, 1'b1},
          '{pk(0, 0, 0, 1, 0, 0), 1'b0, 1'b1},
          '{pk(0, 0, 0, 1, 0, 0), 1'b0, 1'b1},
          '{pk(0, 0, 0, 1, 0, 0), 1'b1, 1'b1},
          '{pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sb.push_back(x[i]);
      apply(p[i]);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL blink step %0d: got %h blink %b, want %h blink %b", i, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_fields();
    logic [4:0] p [0:6];
    logic [20:0] x [0:6];
    p = '{P_C, P_R, P_R, P_R, P_L, P_D, P_U};
    x = '{pk(0, 0, 0, 1, 0, 0), pk(0, 0, 0, 1, 1, 0), pk(0, 0, 0, 1, 2, 0),
          pk(0, 0, 0, 1, 0, 0), pk(0, 0, 0, 1, 2, 0), pk(0, 0, 59, 1, 2, 0),
          pk(0, 0, 0, 1, 2, 0)};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{x[i], 1'b0, 1'b0});
      apply(p[i]);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL fields step %0d: got %h blink %b, want %h blink %b", i, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_priority();
    logic [4:0] p [0:4];
    logic [20:0] x [0:4];
    p = '{P_C | P_U, P_U | P_R, P_D | P_L, P_L | P_R, P_U | P_D};
    x = '{pk(0, 0, 0, 1, 0, 0), pk(1, 0, 0, 1, 0, 0), pk(0, 0, 0, 1, 0, 0),
          pk(0, 0, 0, 1, 2, 0), pk(0, 0, 1, 1, 2, 0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{x[i], 1'b0, 1'b0});
      apply(p[i]);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL priority step %0d: got %h blink %b, want %h blink %b", i, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] p [0:7];
    int         h [0:7];
    p = '{P_C, P_U, P_U, P_U, P_D, P_D, P_D, P_D};
    h = '{0, 1, 2, 3, 2, 1, 0, 23};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{pk(h[i], 0, 0, 1, 0, 0), 1'b0, 1'b0});
      apply(p[i]);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %h blink %b, want %h blink %b", i, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_reset_in_edit();
    logic [4:0] p [0:3];
    logic [20:0] x [0:3];
    p = '{P_C, P_R, P_R, P_U};
    x = '{pk(0, 0, 0, 1, 0, 0), pk(0, 0, 0, 1, 1, 0), pk(0, 0, 0, 1, 2, 0), pk(0, 0, 1, 1, 2, 0)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{x[i], 1'b0, 1'b0});
      apply(p[i]);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL reset_in_edit setup %0d: got %h blink %b, want %h blink %b", i, snap(), blink, e.v, e.b);
      end
    end
    sb.push_back('{pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
    do_reset();
    e = sb.pop_front();
    total++;
    if (snap() !== e.v || (e.cb && blink !== e.b)) begin
      bad++;
      $display("FAIL reset_in_edit: got %h blink %b, want %h blink %b", snap(), blink, e.v, e.b);
    end
  endtask

`ifdef TIME_SET_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    sb.push_back('{pk(0, 0, 0, 1, 0, 0), 1'b1, 1'b1});
    apply(P_C);
    for (int k = 1; k <= 12; k++) begin
      if (k < 8)       sb.push_back('{pk(0, 0, 0, 1, 0, 0), 1'b0, 1'b0});
      else if (k < 12) sb.push_back('{pk(0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
      else             sb.push_back('{pk(0, 0, 1, 0, 0, 1), 1'b0, 1'b1});
      if (k > 1) begin
        step();
      end else begin
        e = sb.pop_front();
        total++;
        if (snap() !== e.v || (e.cb && blink !== e.b)) begin
          bad++;
          $display("FAIL timeout entry: got %h blink %b, want %h blink %b", snap(), blink, e.v, e.b);
        end
        step();
      end
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL timeout cycle %0d: got %h blink %b, want %h blink %b", k, snap(), blink, e.v, e.b);
      end
    end
  endtask

  task automatic test_timeout_restart();
    do_reset();
    apply(P_C);
    for (int k = 1; k <= 13; k++) begin
      if (k < 5)       sb.push_back('{pk(0, 0, 0, 1, 0, 0), 1'b0, 1'b0});
      else if (k < 13) sb.push_back('{pk(1, 0, 0, 1, 0, 0), 1'b0, 1'b0});
      else             sb.push_back('{pk(1, 0, 0, 0, 0, 0), 1'b0, 1'b1});
      apply((k == 5) ? P_U : P_N);
      e = sb.pop_front();
      total++;
      if (snap() !== e.v || (e.cb && blink !== e.b)) begin
        bad++;
        $display("FAIL timeout_restart cycle %0d: got %h blink %b, want %h blink %b", k, snap(), blink, e.v, e.b);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_count();
    test_preload_wrap();
    test_blink();
    test_fields();
    test_priority();
    test_back_to_back();
    test_reset_in_edit();
`ifdef TIME_SET_TIMEOUT_EN
    test_timeout();
    test_timeout_restart();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Timekeeping and time-setting core for the clock display. Consumes the single-cycle button pulses from the button one-pulse stage (U/D/L/R/C) and maintains a 24-hour hh:mm:ss count. Has a RUN mode (counting) and an EDIT mode (counting paused, one field selected and adjusted). Feeds the seven-segment display driver with time, mode, field and blink outputs.

## Interface
- `CLK_HZ`, 100_000_000, clock cycles per second (≥ 2; benches use small values)
- `TIMEOUT_S`, 10, idle seconds before EDIT auto-exits (used only with `TIME_SET_TIMEOUT_EN`)
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high; one clock, all state on `posedge clk`
- `pulseU`, `pulseD`, `pulseL`, `pulseR`, `pulseC` in 1 each: single-cycle button pulses
- `hours` out 5: 0..23
- `minutes` out 6: 0..59
- `seconds` out 6: 0..59
- `edit_mode` out 1: 1 = EDIT, 0 = RUN
- `edit_field` out 2: 0 = hours, 1 = minutes, 2 = seconds; 3 is never driven
- `blink` out 1: display blank phase for the selected field
- `sec_tick` out 1: one-cycle strobe, asserted on each RUN-mode second increment

## Operation
- All outputs are registered. Reset values: time 00:00:00, `edit_mode`=0, `edit_field`=0, `blink`=0, `sec_tick`=0. The prescaler, blink counter and idle counter reset to 0.
- Reset during EDIT returns the block to RUN at 00:00:00.
- Pulse priority: at most one button action per cycle, in order C > U > D > L > R. Lower-priority pulses arriving in the same cycle are dropped.
- RUN state:
  - Prescaler counts 0..CLK_HZ-1. At CLK_HZ-1 it wraps to 0, `sec_tick`=1, and `seconds` increments.
  - Carry: seconds 59→0 increments minutes. Minutes 59→0 increments hours. Hours 23→0. So 23:59:59 → 00:00:00.
  - `pulseC`: go to EDIT with `edit_field`=0 and `blink`=1. The blink counter clears.
  - A tick due on that same edge is still applied.
  - U/D/L/R are ignored in RUN.
- EDIT state:
  - Prescaler is held at 0. `sec_tick`=0.
  - `pulseR`: field 0→1→2→0. `pulseL`: field 0→2→1→0.
  - `pulseU` increments the selected field with wrap: hours 23→0, minutes and seconds 59→0. No carry into other fields.
  - `pulseD` decrements the selected field with wrap: hours 0→23, minutes and seconds 0→59. No borrow.
  - `pulseC`: go to RUN with `blink`=0. The prescaler restarts at 0, so the first tick comes CLK_HZ cycles after exit.
  - Blink counter counts 0..CLK_HZ/2-1. It toggles `blink` on wrap.
- Field widths: all arithmetic is done in the field's own width, with explicit compare-and-wrap. Out-of-range values are unreachable.

## Timing
- Pulse at edge N: its effect is visible on outputs after edge N (one-cycle latency).
- First `sec_tick` after reset or after leaving EDIT: asserted in the CLK_HZ-th cycle. From then on, the period is exactly CLK_HZ cycles.
- `sec_tick` and the new `seconds` value update on the same edge.
- Back-to-back pulses on consecutive cycles are each acted on.

## Configuration
- `TIME_SET_TIMEOUT_EN` defined:
  - An idle counter runs in EDIT. It counts seconds using the blink time base (two blink wraps = 1 s).
  - The counter clears on any accepted pulse.
  - After `TIMEOUT_S` idle seconds, the block returns to RUN exactly as if `pulseC` had arrived. Edited values are kept.
- Not defined: no idle counter; EDIT persists until `pulseC`.

## Test plan
- Reset, CLK_HZ=4, no pulses for 12 cycles → `sec_tick` in cycles 4, 8, 12; `seconds`=3.
- Preload 23:59:59 via EDIT (D on hours, D on minutes, D on seconds), C, wait 4 cycles → 00:00:00 with a single `sec_tick`.
- EDIT, R, R, R → `edit_field` 1, 2, 0. L from 0 → 2. U on seconds at 59 → 0, `minutes` unchanged.
- `pulseC`+`pulseU` in the same cycle in RUN → EDIT entered, no increment. `pulseU`+`pulseR` in EDIT → increment only, field unchanged.
- Reset asserted during EDIT with field=2 → next cycle RUN, 00:00:00, `edit_field`=0, `blink`=0.
- With `TIME_SET_TIMEOUT_EN`, TIMEOUT_S=2, CLK_HZ=4: enter EDIT, no pulses → `edit_mode`=0 after 8 cycles. A U pulse at cycle 5 delays the exit to cycle 13.
